// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the TDC measurement controller.
// State codes are kept as plain constants so legacy decoders can match them.
package tdc_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_RUNNING = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ARMED   = ST_ARMED,
        RUNNING = ST_RUNNING,
        DONE    = ST_DONE
    } tdc_state_e;

    function automatic int tdc_fine_w(input int max_length);
        return $clog2(max_length);
    endfunction

    function automatic int tdc_coarse_w(input int timeout_cycles);
        return $clog2(timeout_cycles) + 1;
    endfunction

    // Extra sign bit on top of coarse*taps + fine so same-cycle skew can go negative.
    function automatic int tdc_interval_w(input int max_length, input int taps_per_clk,
                                          input int timeout_cycles);
        return tdc_coarse_w(timeout_cycles) + $clog2(taps_per_clk + 1) + tdc_fine_w(max_length) + 1;
    endfunction

endpackage

// File: rtl/tdc_coarse_counter.sv
// Coarse clk_input period counter with synchronous clear, enable and a
// terminal-count flag raised while the count sits at TIMEOUT_CYCLES-1.
module tdc_coarse_counter
    import tdc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int COARSE_W = tdc_coarse_w(TIMEOUT_CYCLES)
) (
    input  logic                clk_input,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    output logic [COARSE_W-1:0] count,
    output logic                terminal
);

    logic [COARSE_W-1:0] count_r;

    // Period counter; clear wins over enable.
    always_ff @(posedge clk_input or posedge reset) begin
        if (reset) begin
            count_r <= {COARSE_W{1'b0}};
        end else if (clear) begin
            count_r <= {COARSE_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + COARSE_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count    = count_r;
    assign terminal = (count_r == COARSE_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/tdc_measurement_controller.sv
// Start/stop time-interval sequencer combining coarse periods and fine codes.
// Optional macro TDC_CALIB_EN enables tracking of the maximum start fine code.
module tdc_measurement_controller
    import tdc_pkg::*;
#(
    parameter int MAX_LENGTH     = 2048,
    parameter int TAPS_PER_CLK   = 512,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int AUTO_REARM     = 0,
    localparam int FINE_W     = tdc_fine_w(MAX_LENGTH),
    localparam int COARSE_W   = tdc_coarse_w(TIMEOUT_CYCLES),
    localparam int INTERVAL_W = tdc_interval_w(MAX_LENGTH, TAPS_PER_CLK, TIMEOUT_CYCLES)
) (
    input  logic                         clk_input,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         start_valid,
    input  logic [FINE_W-1:0]            start_fine,
    input  logic                         stop_valid,
    input  logic [FINE_W-1:0]            stop_fine,
    output logic                         busy,
    output logic                         meas_valid,
    input  logic                         meas_ready,
    output logic signed [INTERVAL_W-1:0] meas_interval,
    output logic                         meas_timeout,
    output logic [FINE_W-1:0]            calib_max_code
);

    tdc_state_e            state_r, state_s;
    logic [FINE_W-1:0]     start_code_r, start_code_s;
    logic [INTERVAL_W-1:0] interval_r, interval_s;
    logic                  timeout_r, timeout_s;
    logic                  valid_r, valid_s;
    logic                  busy_r;
    logic                  cnt_clear_s, cnt_enable_s;
    logic [COARSE_W-1:0]   coarse_s;
    logic                  terminal_s;
    logic [INTERVAL_W-1:0] same_cycle_s, running_s;

    tdc_coarse_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_coarse (
        .clk_input(clk_input),
        .reset    (reset),
        .clear    (cnt_clear_s),
        .enable   (cnt_enable_s),
        .count    (coarse_s),
        .terminal (terminal_s)
    );

    // Zero-extended operands; two's-complement wrap yields the signed interval.
    assign same_cycle_s = INTERVAL_W'(start_fine) - INTERVAL_W'(stop_fine);
    assign running_s    = (INTERVAL_W'(coarse_s) + INTERVAL_W'(1)) * INTERVAL_W'(TAPS_PER_CLK)
                        + INTERVAL_W'(start_code_r) - INTERVAL_W'(stop_fine);

    // Next-state and next-result decode.
    always_comb begin
        state_s      = state_r;
        start_code_s = start_code_r;
        interval_s   = interval_r;
        timeout_s    = timeout_r;
        valid_s      = valid_r;
        cnt_clear_s  = 1'b0;
        cnt_enable_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (arm) begin
                    state_s = ARMED;
                end else begin
                    state_s = IDLE;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (start_valid && stop_valid) begin
                    start_code_s = start_fine;
                    interval_s   = same_cycle_s;
                    timeout_s    = 1'b0;
                    valid_s      = 1'b1;
                    state_s      = DONE;
                end else if (start_valid) begin
                    start_code_s = start_fine;
                    cnt_clear_s  = 1'b1;
                    state_s      = RUNNING;
                end else begin
                    state_s = ARMED;
                end
            end
            RUNNING: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (stop_valid) begin
                    interval_s = running_s;
                    timeout_s  = 1'b0;
                    valid_s    = 1'b1;
                    state_s    = DONE;
                end else if (terminal_s) begin
                    interval_s = {INTERVAL_W{1'b0}};
                    timeout_s  = 1'b1;
                    valid_s    = 1'b1;
                    state_s    = DONE;
                end else begin
                    cnt_enable_s = 1'b1;
                    state_s      = RUNNING;
                end
            end
            DONE: begin
                if (meas_ready) begin
                    valid_s = 1'b0;
                    state_s = (AUTO_REARM != 0) ? ARMED : IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, latched start code and registered outputs.
    always_ff @(posedge clk_input or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            start_code_r <= {FINE_W{1'b0}};
            interval_r   <= {INTERVAL_W{1'b0}};
            timeout_r    <= 1'b0;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            start_code_r <= start_code_s;
            interval_r   <= interval_s;
            timeout_r    <= timeout_s;
            valid_r      <= valid_s;
            busy_r       <= (state_s != IDLE);
        end
    end

    assign busy          = busy_r;
    assign meas_valid    = valid_r;
    assign meas_interval = $signed(interval_r);
    assign meas_timeout  = timeout_r;

`ifdef TDC_CALIB_EN
    logic [FINE_W-1:0] calib_r;

    // Running maximum of every start code seen, regardless of state.
    always_ff @(posedge clk_input or posedge reset) begin
        if (reset) begin
            calib_r <= {FINE_W{1'b0}};
        end else if (start_valid && (start_fine > calib_r)) begin
            calib_r <= start_fine;
        end else begin
            calib_r <= calib_r;
        end
    end

    assign calib_max_code = calib_r;
`else
    assign calib_max_code = {FINE_W{1'b0}};
`endif

endmodule

// File: tb/tb_tdc_measurement_controller.sv
// Directed bench for tdc_measurement_controller (TIMEOUT_CYCLES=16, AUTO_REARM=0).
module tb_tdc_measurement_controller;

    localparam int FINE_W     = 11;
    localparam int INTERVAL_W = 27;

    logic                         clk_input = 1'b0;
    logic                         reset = 1'b1;
    logic                         arm = 1'b0;
    logic                         abort = 1'b0;
    logic                         start_valid = 1'b0;
    logic [FINE_W-1:0]            start_fine = '0;
    logic                         stop_valid = 1'b0;
    logic [FINE_W-1:0]            stop_fine = '0;
    logic                         busy;
    logic                         meas_valid;
    logic                         meas_ready = 1'b0;
    logic signed [INTERVAL_W-1:0] meas_interval;
    logic                         meas_timeout;
    logic [FINE_W-1:0]            calib_max_code;

    int checks = 0;
    int failures = 0;
    longint exp_calib;

    tdc_measurement_controller #(
        .MAX_LENGTH    (2048),
        .TAPS_PER_CLK  (512),
        .TIMEOUT_CYCLES(16),
        .AUTO_REARM    (0)
    ) dut (
        .clk_input     (clk_input),
        .reset         (reset),
        .arm           (arm),
        .abort         (abort),
        .start_valid   (start_valid),
        .start_fine    (start_fine),
        .stop_valid    (stop_valid),
        .stop_fine     (stop_fine),
        .busy          (busy),
        .meas_valid    (meas_valid),
        .meas_ready    (meas_ready),
        .meas_interval (meas_interval),
        .meas_timeout  (meas_timeout),
        .calib_max_code(calib_max_code)
    );

    always #5 clk_input = ~clk_input;

    task automatic tick();
        @(posedge clk_input);
        #1;
    endtask

    task automatic check(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic handshake();
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", longint'(busy), 0);
        check("rst_valid", longint'(meas_valid), 0);
        check("rst_interval", longint'(meas_interval), 0);
        check("rst_timeout", longint'(meas_timeout), 0);
        check("rst_calib", longint'(calib_max_code), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Test 1: multi-period interval
        do_arm();
        check("t1_busy", longint'(busy), 1);
        start_valid = 1'b1; start_fine = 11'd100;
        tick();
        start_valid = 1'b0;
        tick();
        tick();
        check("t1_not_yet", longint'(meas_valid), 0);
        stop_valid = 1'b1; stop_fine = 11'd40;
        tick();
        stop_valid = 1'b0;
        check("t1_valid", longint'(meas_valid), 1);
        check("t1_interval", longint'(meas_interval), 1596);
        check("t1_timeout", longint'(meas_timeout), 0);
        handshake();
        check("t1_release", longint'(meas_valid), 0);
        check("t1_idle", longint'(busy), 0);

        // Test 2: same-cycle start/stop, positive and negative
        do_arm();
        start_valid = 1'b1; start_fine = 11'd300;
        stop_valid = 1'b1; stop_fine = 11'd100;
        tick();
        start_valid = 1'b0; stop_valid = 1'b0;
        check("t2a_valid", longint'(meas_valid), 1);
        check("t2a_interval", longint'(meas_interval), 200);
        handshake();
        do_arm();
        start_valid = 1'b1; start_fine = 11'd50;
        stop_valid = 1'b1; stop_fine = 11'd80;
        tick();
        start_valid = 1'b0; stop_valid = 1'b0;
        check("t2b_valid", longint'(meas_valid), 1);
        check("t2b_interval", longint'(meas_interval), -30);
        handshake();

        // Test 3a: timeout 16 cycles after start
        do_arm();
        start_valid = 1'b1; start_fine = 11'd5;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("t3a_early", longint'(meas_valid), 0);
        tick();
        check("t3a_valid", longint'(meas_valid), 1);
        check("t3a_timeout", longint'(meas_timeout), 1);
        check("t3a_interval", longint'(meas_interval), 0);
        handshake();

        // Test 3b: stop on the terminal cycle wins over timeout
        do_arm();
        start_valid = 1'b1; start_fine = 11'd7;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        stop_valid = 1'b1; stop_fine = 11'd3;
        tick();
        stop_valid = 1'b0;
        check("t3b_valid", longint'(meas_valid), 1);
        check("t3b_timeout", longint'(meas_timeout), 0);
        check("t3b_interval", longint'(meas_interval), 8196);

        // Test 4: result held under back-pressure, extra inputs ignored
        start_valid = 1'b1; start_fine = 11'd9;
        stop_valid = 1'b1; stop_fine = 11'd1;
        arm = 1'b1; abort = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", longint'(meas_valid), 1);
            check("t4_hold_interval", longint'(meas_interval), 8196);
        end
        start_valid = 1'b0; stop_valid = 1'b0; arm = 1'b0; abort = 1'b0;
        handshake();
        check("t4_release", longint'(meas_valid), 0);
        check("t4_idle", longint'(busy), 0);

        // Test 5a: abort beats simultaneous stop
        do_arm();
        start_valid = 1'b1; start_fine = 11'd100;
        tick();
        start_valid = 1'b0;
        tick();
        abort = 1'b1; stop_valid = 1'b1; stop_fine = 11'd10;
        tick();
        abort = 1'b0; stop_valid = 1'b0;
        check("t5a_busy", longint'(busy), 0);
        check("t5a_valid", longint'(meas_valid), 0);
        tick();
        check("t5a_no_result", longint'(meas_valid), 0);

        // Test 5b: asynchronous reset mid-measurement
        do_arm();
        start_valid = 1'b1; start_fine = 11'd100;
        tick();
        start_valid = 1'b0;
        tick();
        check("t5b_running", longint'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("t5b_busy", longint'(busy), 0);
        check("t5b_valid", longint'(meas_valid), 0);
        check("t5b_interval", longint'(meas_interval), 0);
        check("t5b_calib", longint'(calib_max_code), 0);
        tick();
        reset = 1'b0;
        tick();

        // Test 6: calibration maximum
`ifdef TDC_CALIB_EN
        exp_calib = 700;
`else
        exp_calib = 0;
`endif
        do_arm();
        start_valid = 1'b1; start_fine = 11'd10;
        tick();
        start_fine = 11'd700;
        tick();
        start_fine = 11'd20;
        tick();
        start_valid = 1'b0;
        check("t6_calib", longint'(calib_max_code), exp_calib);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_abort_idle", longint'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
